// File: rtl/fwd_hazard_tracker_if.sv
// Decode-to-hazard-tracker bundle: the issuing instruction, its source operands,
// and the forwarding selects / stall returned to the pipeline.
interface fwd_hazard_tracker_if #(
  parameter int DEPTH = 2,
  parameter int REG_W = 5,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16,
  parameter int SEL_W = $clog2(DEPTH + 1)
);
  logic             advance;
  logic             flush;
  logic             issue_valid;
  logic             issue_regwr;
  logic [REG_W-1:0] issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [REG_W-1:0] rs_idx;
  logic [REG_W-1:0] rt_idx;
  logic             rs_used;
  logic             rt_used;
  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output advance, flush, issue_valid, issue_regwr, issue_rd, issue_lat,
    output rs_idx, rt_idx, rs_used, rt_used,
    input  fwd_sel_a, fwd_sel_b, stall, stall_count
  );

  modport slave (
    input  advance, flush, issue_valid, issue_regwr, issue_rd, issue_lat,
    input  rs_idx, rt_idx, rs_used, rt_used,
    output fwd_sel_a, fwd_sel_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Forwarding/hazard unit: a DEPTH-deep scoreboard of in-flight destinations that yields
// per-operand bypass selects, load-use stalls and a saturating stall-cycle counter.
module fwd_hazard_tracker #(
  parameter int DEPTH = 2,
  parameter int REG_W = 5,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input logic                 CLK,
  input logic                 nRST,
  fwd_hazard_tracker_if.slave bus
);

  logic             r_valid [1:DEPTH];
  logic             r_regwr [1:DEPTH];
  logic [REG_W-1:0] r_rd    [1:DEPTH];
  logic [LAT_W-1:0] r_cnt   [1:DEPTH];
  logic [CNT_W-1:0] r_stall_count;

  logic [1:0]       w_used;
  logic [REG_W-1:0] w_idx [2];
  logic [SEL_W-1:0] w_sel [2];
  logic [1:0]       w_req;
  logic             w_stall;

  assign w_used   = {bus.rt_used, bus.rs_used};
  assign w_idx[0] = bus.rs_idx;
  assign w_idx[1] = bus.rt_idx;

  // Per-operand lookup; scanning oldest to youngest lets the youngest match win
  always_comb begin
    for (int op = 0; op < 2; op++) begin
      w_sel[op] = {SEL_W{1'b0}};
      w_req[op] = 1'b0;
      if (w_used[op] && (w_idx[op] != {REG_W{1'b0}})) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (r_valid[k] && r_regwr[k] && (r_rd[k] == w_idx[op])) begin
            if (r_cnt[k] == {LAT_W{1'b0}}) begin
              w_sel[op] = SEL_W'(k);
              w_req[op] = 1'b0;
            end else begin
              w_sel[op] = {SEL_W{1'b0}};
              w_req[op] = 1'b1;
            end
          end else begin
            w_sel[op] = w_sel[op];
            w_req[op] = w_req[op];
          end
        end
      end else begin
        w_sel[op] = {SEL_W{1'b0}};
        w_req[op] = 1'b0;
      end
    end
  end

  assign w_stall = bus.issue_valid & (w_req[0] | w_req[1]);

  // Scoreboard shift on advance; slot 1 takes the issuing instruction or a bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_regwr[k] <= 1'b0;
        r_rd[k]    <= {REG_W{1'b0}};
        r_cnt[k]   <= {LAT_W{1'b0}};
      end
      r_stall_count <= {CNT_W{1'b0}};
    end else if (bus.advance) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_regwr[k] <= r_regwr[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_cnt[k]   <= (r_cnt[k-1] != {LAT_W{1'b0}}) ? (r_cnt[k-1] - LAT_W'(1)) : {LAT_W{1'b0}};
      end
      r_valid[1] <= ~(bus.flush | w_stall | ~bus.issue_valid);
      r_regwr[1] <= bus.issue_regwr & (bus.issue_rd != {REG_W{1'b0}});
      r_rd[1]    <= bus.issue_rd;
      // A latency of 0 behaves like 1, so both leave slot 1 immediately forwardable
      r_cnt[1]   <= (bus.issue_lat == {LAT_W{1'b0}}) ? {LAT_W{1'b0}} : (bus.issue_lat - LAT_W'(1));
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end else begin
        r_stall_count <= r_stall_count;
      end
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign bus.fwd_sel_a   = w_sel[0];
  assign bus.fwd_sel_b   = w_sel[1];
  assign bus.stall       = w_stall;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Bench for fwd_hazard_tracker: directed scenarios then random traffic, all checked
// against an age/latency model of the in-flight instructions.
`timescale 1ns/1ps
module tb_fwd_hazard_tracker;
  localparam int DEPTH = 2;
  localparam int REG_W = 5;
  localparam int LAT_W = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  fwd_hazard_tracker_if #(.DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus();

  fwd_hazard_tracker #(.DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  // Model: list of issued instructions, youngest first; list position + 1 is its age.
  typedef struct {
    bit bubble;
    bit writes;
    int rd;
    int lat;
  } ent_t;

  ent_t q[$];
  int   m_count;
  int   exp_sel [2];
  bit   exp_req [2];
  bit   exp_stall;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input string field, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0d expected=%0d", tag, field, got, exp);
    end
  endtask

  task automatic ref_eval();
    bit used [2];
    int idx  [2];
    used[0] = bus.rs_used; idx[0] = int'(bus.rs_idx);
    used[1] = bus.rt_used; idx[1] = int'(bus.rt_idx);
    for (int op = 0; op < 2; op++) begin
      exp_sel[op] = 0;
      exp_req[op] = 1'b0;
      if (used[op] && idx[op] != 0) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].bubble && q[i].writes && q[i].rd == idx[op]) begin
            if (i + 1 >= q[i].lat) exp_sel[op] = i + 1;
            else exp_req[op] = 1'b1;
            break;
          end
        end
      end
    end
    exp_stall = bus.issue_valid && (exp_req[0] || exp_req[1]);
  endtask

  task automatic ref_advance();
    ent_t e;
    if (exp_stall) m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
    e.bubble = bus.flush || exp_stall || !bus.issue_valid;
    e.writes = bus.issue_regwr && (bus.issue_rd != '0);
    e.rd     = int'(bus.issue_rd);
    e.lat    = (bus.issue_lat == '0) ? 1 : int'(bus.issue_lat);
    q.push_front(e);
    if (q.size() > DEPTH) void'(q.pop_back());
  endtask

  task automatic model_chk(input string tag);
    ref_eval();
    chk(tag, "sel_a", int'(bus.fwd_sel_a), exp_sel[0]);
    chk(tag, "sel_b", int'(bus.fwd_sel_b), exp_sel[1]);
    chk(tag, "stall", int'(bus.stall), int'(exp_stall));
    chk(tag, "count", int'(bus.stall_count), m_count);
  endtask

  task automatic drive(input string tag, input bit adv, input bit fl, input bit iv, input bit rw,
                       input int rd, input int lat, input bit rsu, input int rs, input bit rtu, input int rt);
    bus.advance     = adv;
    bus.flush       = fl;
    bus.issue_valid = iv;
    bus.issue_regwr = rw;
    bus.issue_rd    = REG_W'(rd);
    bus.issue_lat   = LAT_W'(lat);
    bus.rs_used     = rsu;
    bus.rs_idx      = REG_W'(rs);
    bus.rt_used     = rtu;
    bus.rt_idx      = REG_W'(rt);
    #1;
    model_chk(tag);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (bus.advance && nRST) ref_advance();
    @(negedge CLK);
  endtask

  task automatic expect_now(input string tag, input int a, input int b, input int st);
    chk(tag, "fixed_sel_a", int'(bus.fwd_sel_a), a);
    chk(tag, "fixed_sel_b", int'(bus.fwd_sel_b), b);
    chk(tag, "fixed_stall", int'(bus.stall), st);
  endtask

  initial begin
    nRST = 1'b0;
    q.delete();
    m_count = 0;
    @(negedge CLK);
    drive("reset", 1, 0, 1, 1, 3, 1, 1, 3, 1, 3);
    expect_now("reset", 0, 0, 0);
    chk("reset", "fixed_count", int'(bus.stall_count), 0);
    tick();
    nRST = 1'b1;

    // ALU dependency ages through slot 1, slot 2, then the register file
    drive("alu_issue", 1, 0, 1, 1, 3, 1, 0, 0, 0, 0); tick();
    drive("alu_s1", 1, 0, 1, 1, 9, 1, 1, 3, 0, 0); expect_now("alu_s1", 1, 0, 0); tick();
    drive("alu_s2", 1, 0, 1, 0, 0, 1, 1, 3, 0, 0); expect_now("alu_s2", 2, 0, 0); tick();
    drive("alu_rf", 1, 0, 0, 0, 0, 1, 1, 3, 0, 0); expect_now("alu_rf", 0, 0, 0); tick();

    // Load-use: one stall, then forward from slot 2
    drive("ld_issue", 1, 0, 1, 1, 5, 2, 0, 0, 0, 0); tick();
    drive("ld_use", 1, 0, 1, 1, 6, 1, 0, 0, 1, 5); expect_now("ld_use", 0, 0, 1); tick();
    drive("ld_fwd", 1, 0, 1, 1, 6, 1, 0, 0, 1, 5); expect_now("ld_fwd", 0, 2, 0);
    chk("ld_fwd", "fixed_count", int'(bus.stall_count), 1); tick();

    // Youngest producer wins, including a pending young load over a ready old one
    drive("yw_p1", 1, 0, 1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive("yw_p2", 1, 0, 1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive("yw_rd", 1, 0, 1, 0, 0, 1, 1, 4, 1, 4); expect_now("yw_rd", 1, 1, 0); tick();
    drive("yw_p3", 1, 0, 1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive("yw_ld", 1, 0, 1, 1, 4, 2, 0, 0, 0, 0); tick();
    drive("yw_stall", 1, 0, 1, 0, 0, 1, 1, 4, 0, 0); expect_now("yw_stall", 0, 0, 1); tick();

    // r0 never forwards; an unused operand never stalls
    drive("r0_prod", 1, 0, 1, 1, 0, 1, 1, 0, 0, 0); expect_now("r0_prod", 0, 0, 0); tick();
    drive("r0_read", 1, 0, 1, 0, 0, 1, 1, 0, 0, 0); expect_now("r0_read", 0, 0, 0); tick();
    drive("unused_ld", 1, 0, 1, 1, 7, 2, 0, 0, 0, 0); tick();
    drive("unused_rt", 0, 0, 1, 0, 0, 1, 0, 0, 0, 7); expect_now("unused_rt", 0, 0, 0); tick();

    // Freeze: pending load stays pending and the counter does not move
    for (int i = 0; i < 3; i++) begin
      drive("freeze", 0, 0, 1, 0, 0, 1, 0, 0, 1, 7); expect_now("freeze", 0, 0, 1); tick();
    end
    chk("freeze", "fixed_count", int'(bus.stall_count), 2);
    drive("thaw", 1, 0, 1, 0, 0, 1, 0, 0, 1, 7); expect_now("thaw", 0, 0, 1); tick();
    drive("thaw_fwd", 1, 0, 1, 0, 0, 1, 0, 0, 1, 7); expect_now("thaw_fwd", 0, 2, 0); tick();

    // Flushed producer leaves no trace
    drive("flush", 1, 1, 1, 1, 12, 1, 0, 0, 0, 0); tick();
    drive("flush_s1", 1, 0, 1, 0, 0, 1, 1, 12, 0, 0); expect_now("flush_s1", 0, 0, 0); tick();
    drive("flush_s2", 1, 0, 1, 0, 0, 1, 1, 12, 0, 0); expect_now("flush_s2", 0, 0, 0); tick();
    chk("flush", "fixed_count", int'(bus.stall_count), 3);

    // Repeated 3-cycle loads feeding the next instruction: 20 stall cycles saturate the counter
    for (int i = 0; i < 30; i++) begin
      drive("sat", 1, 0, 1, 1, 8, 3, 1, 8, 0, 0); tick();
    end
    chk("sat", "fixed_count", int'(bus.stall_count), CNT_MAX);

    // Asynchronous reset in the middle of a stall
    drive("rst_a", 1, 0, 1, 1, 8, 3, 1, 8, 0, 0); tick();
    drive("rst_b", 1, 0, 1, 1, 8, 3, 1, 8, 0, 0); expect_now("rst_b", 0, 0, 1);
    #1 nRST = 1'b0;
    #1;
    q.delete();
    m_count = 0;
    model_chk("rst_mid");
    expect_now("rst_mid", 0, 0, 0);
    chk("rst_mid", "fixed_count", int'(bus.stall_count), 0);
    tick();
    nRST = 1'b1;

    // Random traffic over a small register set to force frequent collisions
    for (int i = 0; i < 400; i++) begin
      drive("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
